dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-port round-robin arbiter and sequencer in front of the 2 KB data memory.
- Port 0 serves the core load/store unit; port 1 serves the debug/DMA master.
- Accepts at most one request per cycle and registers the command toward the memory (combinational read, synchronous write).
- Returns a registered response to the winning port; full throughput of one access per cycle.

Parameters:
- ADDR_W, 11, byte address width of memory and request ports
- DATA_W, 32, data width
- PRIO_INIT, 0, port that wins the first contested arbitration after reset (0 or 1)

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_req0_valid  in  1  port 0 request valid
- o_req0_ready  out  1  port 0 request accepted this cycle
- i_req0_addr  in  ADDR_W  port 0 byte address
- i_req0_wdata  in  DATA_W  port 0 write data (byte/half in low bits)
- i_req0_bmask  in  4  port 0 size: 1111 word, 0011 half, 0001 byte
- i_req0_wren  in  1  port 0 write (1) / read (0)
- o_rsp0_valid  out  1  port 0 response valid
- o_rsp0_rdata  out  DATA_W  port 0 read data (0 for writes)
- o_rsp0_err  out  1  port 0 access rejected
- i_req1_valid, o_req1_ready, i_req1_addr, i_req1_wdata, i_req1_bmask, i_req1_wren, o_rsp1_valid, o_rsp1_rdata, o_rsp1_err: same as port 0, for port 1
- o_mem_addr  out  ADDR_W  memory byte address
- o_mem_wdata  out  DATA_W  memory write data
- o_mem_bmask  out  4  memory byte mask
- o_mem_wren  out  1  memory write enable
- i_mem_rdata  in  DATA_W  memory combinational read data

Behaviour:
- Reset (async, i_rst_n=0): all outputs 0; pipeline valids cleared; last_grant = ~PRIO_INIT.
- Arbitration (combinational, cycle N):
  - Only one port valid: that port is granted.
  - Both valid: the port != last_grant is granted.
  - o_reqX_ready = grant to port X; no other stall source.
  - last_grant updates only on an accept.
- Stage C (cycle N+1):
  - Registered cmd_valid, cmd_port, addr, wdata, bmask, wren, err drive o_mem_*.
  - o_mem_wren = cmd_valid & wren & ~err.
  - When cmd_valid=0 or err=1: o_mem_wren=0, o_mem_bmask=0000, o_mem_addr=0, o_mem_wdata=0.
  - Write commits at the posedge ending N+1.
  - For reads, i_mem_rdata is sampled at the same edge.
- Stage R (cycle N+2):
  - o_rspX_valid=1 for exactly one cycle, X = cmd_port.
  - rdata = sampled i_mem_rdata for reads; 0 for writes and for err.
  - Non-winning port response outputs are 0.
- Latency: request to response is 2 cycles; back-to-back accepts produce back-to-back responses in order.
- Read after write to the same address in the next accept returns the new data (write commits before the read's stage C).
- Reset mid-operation: in-flight command and response are dropped. A write in stage C is not committed if i_rst_n falls before its edge.
- Request fields must be held stable while valid and not ready.

Optional Feature:
- Macro: DMEM_ARB_ALIGN_CHK_EN.
- Defined, an accepted request gets err=1 when any of these holds:
  - bmask=1111 and addr[1:0]!=00
  - bmask=0011 and addr[0]=1
  - bmask not in {1111, 0011, 0001}
- On err: no memory write, response valid with o_rspX_err=1, rdata=0.
- Not defined: err is tied 0; every request is passed to memory unchanged.

Test Plan:
- Reset then port 0 write word 0xDEADBEEF @0x010, then read @0x010 → ready same cycle each; rsp0_valid at +2 cycles; read rdata=0xDEADBEEF, write rdata=0.
- Both ports valid continuously for 4 cycles, PRIO_INIT=0 → grants 0,1,0,1; responses alternate rsp0/rsp1 two cycles later.
- Port 1 byte write 0xAB @0x013 over word 0x11223344, then word read → 0xAB223344.
- Assert i_rst_n=0 while a write to @0x020 is in stage C → o_mem_wren drops immediately; later read @0x020 returns old value; no response emitted.
- With DMEM_ARB_ALIGN_CHK_EN: port 0 word write @0x002 → rsp0_err=1, rdata=0, o_mem_wren never 1. Without the macro: same request drives o_mem_wren=1, err=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and two-stage sequencer for the data memory.
// Optional alignment checking is enabled by defining DMEM_ARB_ALIGN_CHK_EN.
module dmem_arbiter #(
   parameter int ADDR_W    = 11,
   parameter int DATA_W    = 32,
   parameter int PRIO_INIT = 0
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req0_valid,
   output logic              o_req0_ready,
   input  logic [ADDR_W-1:0] i_req0_addr,
   input  logic [DATA_W-1:0] i_req0_wdata,
   input  logic [3:0]        i_req0_bmask,
   input  logic              i_req0_wren,
   output logic              o_rsp0_valid,
   output logic [DATA_W-1:0] o_rsp0_rdata,
   output logic              o_rsp0_err,
   input  logic              i_req1_valid,
   output logic              o_req1_ready,
   input  logic [ADDR_W-1:0] i_req1_addr,
   input  logic [DATA_W-1:0] i_req1_wdata,
   input  logic [3:0]        i_req1_bmask,
   input  logic              i_req1_wren,
   output logic              o_rsp1_valid,
   output logic [DATA_W-1:0] o_rsp1_rdata,
   output logic              o_rsp1_err,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   output logic [3:0]        o_mem_bmask,
   output logic              o_mem_wren,
   input  logic [DATA_W-1:0] i_mem_rdata
);

   localparam logic LAST_INIT = (PRIO_INIT == 0) ? 1'b1 : 1'b0;

   logic              last_grant;
   logic              grant0, grant1, accept;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [3:0]        sel_bmask;
   logic              sel_wren, sel_err;

   logic              cmd_valid, cmd_port, cmd_wren, cmd_err;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic [3:0]        cmd_bmask;
   logic              cmd_live;
   logic [DATA_W-1:0] rsp_data;

   // On contention the port that did not win last time is served.
   always_comb begin
      grant0    = i_req0_valid & (~i_req1_valid | last_grant);
      grant1    = i_req1_valid & (~i_req0_valid | ~last_grant);
      accept    = grant0 | grant1;
      sel_addr  = grant1 ? i_req1_addr  : i_req0_addr;
      sel_wdata = grant1 ? i_req1_wdata : i_req0_wdata;
      sel_bmask = grant1 ? i_req1_bmask : i_req0_bmask;
      sel_wren  = grant1 ? i_req1_wren  : i_req0_wren;
`ifdef DMEM_ARB_ALIGN_CHK_EN
      sel_err   = ((sel_bmask == 4'b1111) && (sel_addr[1:0] != 2'b00)) ||
                  ((sel_bmask == 4'b0011) && sel_addr[0]) ||
                  !((sel_bmask == 4'b1111) || (sel_bmask == 4'b0011) ||
                    (sel_bmask == 4'b0001));
`else
      sel_err   = 1'b0;
`endif
   end

   assign o_req0_ready = grant0 & i_rst_n;
   assign o_req1_ready = grant1 & i_rst_n;

   // Rejected or idle commands present an all-zero bus to the memory.
   assign cmd_live    = cmd_valid & ~cmd_err;
   assign o_mem_addr  = cmd_live ? cmd_addr  : '0;
   assign o_mem_wdata = cmd_live ? cmd_wdata : '0;
   assign o_mem_bmask = cmd_live ? cmd_bmask : 4'b0000;
   assign o_mem_wren  = cmd_live & cmd_wren;
   assign rsp_data    = (cmd_live & ~cmd_wren) ? i_mem_rdata : '0;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         last_grant   <= LAST_INIT;
         cmd_valid    <= 1'b0;
         cmd_port     <= 1'b0;
         cmd_addr     <= '0;
         cmd_wdata    <= '0;
         cmd_bmask    <= 4'b0000;
         cmd_wren     <= 1'b0;
         cmd_err      <= 1'b0;
         o_rsp0_valid <= 1'b0;
         o_rsp0_rdata <= '0;
         o_rsp0_err   <= 1'b0;
         o_rsp1_valid <= 1'b0;
         o_rsp1_rdata <= '0;
         o_rsp1_err   <= 1'b0;
      end else begin
         cmd_valid <= accept;
         if (accept) begin
            last_grant <= grant1;
            cmd_port   <= grant1;
            cmd_addr   <= sel_addr;
            cmd_wdata  <= sel_wdata;
            cmd_bmask  <= sel_bmask;
            cmd_wren   <= sel_wren;
            cmd_err    <= sel_err;
         end
         o_rsp0_valid <= cmd_valid & ~cmd_port;
         o_rsp0_rdata <= cmd_port ? '0 : rsp_data;
         o_rsp0_err   <= cmd_valid & ~cmd_port & cmd_err;
         o_rsp1_valid <= cmd_valid & cmd_port;
         o_rsp1_rdata <= cmd_port ? rsp_data : '0;
         o_rsp1_err   <= cmd_valid & cmd_port & cmd_err;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural data memory.
module tb_dmem_arbiter;

   localparam int ADDR_W = 11;
   localparam int DATA_W = 32;
`ifdef DMEM_ARB_ALIGN_CHK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   logic              i_clk = 1'b0;
   logic              i_rst_n;
   logic              i_req0_valid, i_req0_wren, o_req0_ready;
   logic [ADDR_W-1:0] i_req0_addr;
   logic [DATA_W-1:0] i_req0_wdata;
   logic [3:0]        i_req0_bmask;
   logic              o_rsp0_valid, o_rsp0_err;
   logic [DATA_W-1:0] o_rsp0_rdata;
   logic              i_req1_valid, i_req1_wren, o_req1_ready;
   logic [ADDR_W-1:0] i_req1_addr;
   logic [DATA_W-1:0] i_req1_wdata;
   logic [3:0]        i_req1_bmask;
   logic              o_rsp1_valid, o_rsp1_err;
   logic [DATA_W-1:0] o_rsp1_rdata;
   logic [ADDR_W-1:0] o_mem_addr;
   logic [DATA_W-1:0] o_mem_wdata;
   logic [3:0]        o_mem_bmask;
   logic              o_mem_wren;
   logic [DATA_W-1:0] i_mem_rdata;

   int checks   = 0;
   int failures = 0;

   always #5 i_clk = ~i_clk;

   dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PRIO_INIT(0)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready),
      .i_req0_addr(i_req0_addr), .i_req0_wdata(i_req0_wdata),
      .i_req0_bmask(i_req0_bmask), .i_req0_wren(i_req0_wren),
      .o_rsp0_valid(o_rsp0_valid), .o_rsp0_rdata(o_rsp0_rdata), .o_rsp0_err(o_rsp0_err),
      .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready),
      .i_req1_addr(i_req1_addr), .i_req1_wdata(i_req1_wdata),
      .i_req1_bmask(i_req1_bmask), .i_req1_wren(i_req1_wren),
      .o_rsp1_valid(o_rsp1_valid), .o_rsp1_rdata(o_rsp1_rdata), .o_rsp1_err(o_rsp1_err),
      .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
      .o_mem_bmask(o_mem_bmask), .o_mem_wren(o_mem_wren),
      .i_mem_rdata(i_mem_rdata)
   );

   // Memory steers size-coded mask and low-aligned data onto byte lanes.
   logic [31:0] mem [0:511];
   assign i_mem_rdata = mem[o_mem_addr[10:2]];

   always @(posedge i_clk) begin
      if (o_mem_wren) begin
         logic [7:0]  lanes;
         logic [63:0] sh;
         lanes = {4'b0000, o_mem_bmask} << o_mem_addr[1:0];
         sh    = {32'd0, o_mem_wdata} << (8 * o_mem_addr[1:0]);
         for (int b = 0; b < 4; b++)
            if (lanes[b]) mem[o_mem_addr[10:2]][8*b +: 8] <= sh[8*b +: 8];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic req0(input logic v, input logic [10:0] a, input logic [31:0] d,
                       input logic [3:0] m, input logic w);
      i_req0_valid = v; i_req0_addr = a; i_req0_wdata = d; i_req0_bmask = m; i_req0_wren = w;
   endtask

   task automatic req1(input logic v, input logic [10:0] a, input logic [31:0] d,
                       input logic [3:0] m, input logic w);
      i_req1_valid = v; i_req1_addr = a; i_req1_wdata = d; i_req1_bmask = m; i_req1_wren = w;
   endtask

   task automatic idle();
      req0(1'b0, 11'h000, 32'h0, 4'h0, 1'b0);
      req1(1'b0, 11'h000, 32'h0, 4'h0, 1'b0);
   endtask

   initial begin
      i_rst_n = 1'b0;
      idle();
      repeat (2) @(negedge i_clk);
      chk("rst_ready0", o_req0_ready, 0);
      chk("rst_ready1", o_req1_ready, 0);
      chk("rst_rsp0_valid", o_rsp0_valid, 0);
      chk("rst_rsp1_valid", o_rsp1_valid, 0);
      chk("rst_mem_wren", o_mem_wren, 0);
      chk("rst_mem_addr", o_mem_addr, 0);
      i_rst_n = 1'b1;

      // Port 0 word write then read back
      @(negedge i_clk);
      req0(1'b1, 11'h010, 32'hDEADBEEF, 4'hF, 1'b1);
      #1 chk("t1_wr_ready0", o_req0_ready, 1);
      @(negedge i_clk);
      chk("t1_mem_wren", o_mem_wren, 1);
      chk("t1_mem_addr", o_mem_addr, 32'h010);
      chk("t1_mem_wdata", o_mem_wdata, 32'hDEADBEEF);
      req0(1'b1, 11'h010, 32'h0, 4'hF, 1'b0);
      #1 chk("t1_rd_ready0", o_req0_ready, 1);
      @(negedge i_clk);
      chk("t1_wr_rsp_valid", o_rsp0_valid, 1);
      chk("t1_wr_rsp_rdata", o_rsp0_rdata, 0);
      chk("t1_wr_rsp1_valid", o_rsp1_valid, 0);
      chk("t1_rd_mem_wren", o_mem_wren, 0);
      idle();
      @(negedge i_clk);
      chk("t1_rd_rsp_valid", o_rsp0_valid, 1);
      chk("t1_rd_rsp_rdata", o_rsp0_rdata, 32'hDEADBEEF);
      @(negedge i_clk);
      chk("t1_rsp_done", o_rsp0_valid, 0);

      // Setup for alternation: port 1 writes @0x040, then fresh reset
      req1(1'b1, 11'h040, 32'h55AA55AA, 4'hF, 1'b1);
      @(negedge i_clk);
      idle();
      repeat (3) @(negedge i_clk);
      i_rst_n = 1'b0;
      @(negedge i_clk);
      i_rst_n = 1'b1;

      // Both ports contend for 4 cycles: grants 0,1,0,1
      for (int i = 0; i < 6; i++) begin
         @(negedge i_clk);
         if (i >= 2) begin
            chk($sformatf("t2_rsp0_valid_%0d", i), o_rsp0_valid, ((i - 2) % 2 == 0));
            chk($sformatf("t2_rsp1_valid_%0d", i), o_rsp1_valid, ((i - 2) % 2 == 1));
            if ((i - 2) % 2 == 0)
               chk($sformatf("t2_rsp0_rdata_%0d", i), o_rsp0_rdata, 32'hDEADBEEF);
            else
               chk($sformatf("t2_rsp1_rdata_%0d", i), o_rsp1_rdata, 32'h55AA55AA);
         end
         if (i < 4) begin
            req0(1'b1, 11'h010, 32'h0, 4'hF, 1'b0);
            req1(1'b1, 11'h040, 32'h0, 4'hF, 1'b0);
            #1;
            chk($sformatf("t2_ready0_%0d", i), o_req0_ready, (i % 2 == 0));
            chk($sformatf("t2_ready1_%0d", i), o_req1_ready, (i % 2 == 1));
         end else if (i == 4) begin
            idle();
         end
      end

      // Port 1 byte write into a word
      @(negedge i_clk);
      req1(1'b1, 11'h010, 32'h11223344, 4'hF, 1'b1);
      #1 chk("t3_ready1", o_req1_ready, 1);
      @(negedge i_clk);
      req1(1'b1, 11'h013, 32'h000000AB, 4'h1, 1'b1);
      @(negedge i_clk);
      chk("t3_mem_addr", o_mem_addr, 32'h013);
      chk("t3_mem_bmask", o_mem_bmask, 32'h1);
      chk("t3_mem_wdata", o_mem_wdata, 32'hAB);
      req1(1'b1, 11'h010, 32'h0, 4'hF, 1'b0);
      @(negedge i_clk);
      idle();
      chk("t3_bw_rsp1_valid", o_rsp1_valid, 1);
      @(negedge i_clk);
      chk("t3_rd_rsp1_valid", o_rsp1_valid, 1);
      chk("t3_rd_rsp0_valid", o_rsp0_valid, 0);
      chk("t3_rd_rdata", o_rsp1_rdata, 32'hAB223344);

      // Reset while a write sits in stage C
      @(negedge i_clk);
      req0(1'b1, 11'h020, 32'hCAFEF00D, 4'hF, 1'b1);
      @(negedge i_clk);
      idle();
      repeat (2) @(negedge i_clk);
      req0(1'b1, 11'h020, 32'h0BADBEEF, 4'hF, 1'b1);
      @(negedge i_clk);
      idle();
      chk("t4_wren_before", o_mem_wren, 1);
      #1 i_rst_n = 1'b0;
      #1 chk("t4_wren_dropped", o_mem_wren, 0);
      chk("t4_addr_dropped", o_mem_addr, 0);
      @(negedge i_clk);
      chk("t4_no_rsp_in_rst", o_rsp0_valid, 0);
      i_rst_n = 1'b1;
      @(negedge i_clk);
      chk("t4_no_rsp_after", o_rsp0_valid, 0);
      req0(1'b1, 11'h020, 32'h0, 4'hF, 1'b0);
      @(negedge i_clk);
      idle();
      @(negedge i_clk);
      chk("t4_rd_valid", o_rsp0_valid, 1);
      chk("t4_rd_old", o_rsp0_rdata, 32'hCAFEF00D);

      // Misaligned word write
      @(negedge i_clk);
      req0(1'b1, 11'h002, 32'h12345678, 4'hF, 1'b1);
      #1 chk("t5_ready0", o_req0_ready, 1);
      @(negedge i_clk);
      idle();
      chk("t5_mem_wren", o_mem_wren, ALIGN ? 0 : 1);
      chk("t5_mem_addr", o_mem_addr, ALIGN ? 32'h0 : 32'h002);
      @(negedge i_clk);
      chk("t5_rsp_valid", o_rsp0_valid, 1);
      chk("t5_rsp_err", o_rsp0_err, ALIGN);
      chk("t5_rsp_rdata", o_rsp0_rdata, 0);
      chk("t5_mem_wren_after", o_mem_wren, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
